// File: rtl/int_ctrl_multi.sv
// Two-level priority interrupt controller with IE/IP registers, edge/level pending
// latches, irq/ack handshake and nested in-service tracking.
// Optional macro INT_CTRL_SW_TRIG_EN enables software-triggered pending (op 6).
module int_ctrl_multi #(
    parameter int unsigned       N_SRC     = 5,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [N_SRC-1:0]  EDGE_MASK = 5'b00101,
    parameter int unsigned       VEC_W     = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_byte,
    input  logic [2:0]        i_op,
    input  logic [N_SRC-1:0]  i_src,
    input  logic              i_ack,
    input  logic              i_reti,
    output logic [DATA_W-1:0] o_ie,
    output logic [DATA_W-1:0] o_ip,
    output logic [N_SRC-1:0]  o_pend,
    output logic              o_irq,
    output logic [VEC_W-1:0]  o_vec,
    output logic [1:0]        o_isr
);

    localparam int unsigned ADDR_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] OP_IE_BYTE  = 3'd1;
    localparam logic [2:0] OP_IE_BIT   = 3'd2;
    localparam logic [2:0] OP_IP_BYTE  = 3'd3;
    localparam logic [2:0] OP_IP_BIT   = 3'd4;
    localparam logic [2:0] OP_PEND_CLR = 3'd5;
    localparam logic [2:0] OP_PEND_SET = 3'd6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [DATA_W-1:0] r_ie, r_ip;
    logic [N_SRC-1:0]  r_pend, r_src_q;
    logic [1:0]        r_isr;
    logic              r_irq;
    logic [VEC_W-1:0]  r_vec;
    logic [0:0]        r_state;

    logic [DATA_W-1:0] w_ie_nxt, w_ip_nxt, w_bit_mask;
    logic [N_SRC-1:0]  w_pend_nxt, w_src_mask, w_pclr, w_pset_sw, w_ack_clr;
    logic [N_SRC-1:0]  w_elig, w_hi, w_vec_oh, w_rise;
    logic [1:0]        w_isr_nxt, w_isr_ret, w_isr_set;
    logic              w_irq_nxt, w_val, w_allowed, w_vec_hi, w_vec_elig;
    logic [VEC_W-1:0]  w_vec_nxt, w_cand;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_addr;

    // Register-access decode: byte/bit writes of IE/IP and pending bit ops
    always_comb begin
        w_addr     = i_byte[ADDR_W:1];
        w_val      = i_byte[0];
        w_bit_mask = (32'(w_addr) < DATA_W) ? (DATA_W'(1) << w_addr) : '0;
        w_src_mask = (32'(w_addr) < N_SRC)  ? (N_SRC'(1) << w_addr)  : '0;
        w_ie_nxt   = r_ie;
        w_ip_nxt   = r_ip;
        w_pclr     = '0;
        w_pset_sw  = '0;
        case (i_op)
            OP_IE_BYTE:  w_ie_nxt = i_byte;
            OP_IE_BIT:   w_ie_nxt = w_val ? (r_ie | w_bit_mask) : (r_ie & ~w_bit_mask);
            OP_IP_BYTE:  w_ip_nxt = i_byte;
            OP_IP_BIT:   w_ip_nxt = w_val ? (r_ip | w_bit_mask) : (r_ip & ~w_bit_mask);
            OP_PEND_CLR: w_pclr   = w_src_mask;
`ifdef INT_CTRL_SW_TRIG_EN
            OP_PEND_SET: w_pset_sw = w_src_mask & EDGE_MASK;
`else
            OP_PEND_SET: w_pset_sw = '0;
`endif
            default: ;
        endcase
    end

    // Eligibility and winner: lowest-index high-priority source, else lowest-index eligible
    always_comb begin
        w_elig = r_pend & r_ie[N_SRC-1:0] & {N_SRC{r_ie[DATA_W-1]}};
        w_hi   = w_elig & r_ip[N_SRC-1:0];
        w_cand = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (w_elig[i]) w_cand = VEC_W'(i);
        end
        if (|w_hi) begin
            for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
                if (w_hi[i]) w_cand = VEC_W'(i);
            end
        end
        w_allowed  = (|w_elig) && ((r_isr == 2'b00) || ((r_isr == 2'b01) && (|w_hi)));
        w_vec_oh   = N_SRC'(1) << r_vec;
        w_vec_hi   = |(w_vec_oh & r_ip[N_SRC-1:0]);
        w_vec_elig = |(w_vec_oh & w_elig);
    end

    // Handshake FSM next-state and registered-output values
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_vec_nxt   = r_vec;
        w_isr_set   = 2'b00;
        w_ack_clr   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_allowed) begin
                    w_vec_nxt   = w_cand;
                    w_irq_nxt   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (i_ack) begin
                    w_irq_nxt   = 1'b0;
                    w_isr_set   = w_vec_hi ? 2'b10 : 2'b01;
                    w_ack_clr   = w_vec_oh & EDGE_MASK;
                    w_state_nxt = S_IDLE;
                end else if (!w_vec_elig) begin
                    w_irq_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_irq_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // reti retires the innermost level before an ack in the same cycle sets its flag
        w_isr_ret = r_isr;
        if (i_reti) begin
            if (r_isr[1]) w_isr_ret[1] = 1'b0;
            else          w_isr_ret[0] = 1'b0;
        end
        w_isr_nxt = w_isr_ret | w_isr_set;

        // Edge sources: set beats clear; level sources just follow the input
        w_rise     = i_src & ~r_src_q;
        w_pend_nxt = (EDGE_MASK & ((r_pend & ~(w_pclr | w_ack_clr)) | w_rise | w_pset_sw))
                   | (~EDGE_MASK & i_src);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ie    <= '0;
            r_ip    <= '0;
            r_pend  <= '0;
            r_src_q <= '0;
            r_isr   <= 2'b00;
            r_irq   <= 1'b0;
            r_vec   <= '0;
            r_state <= S_IDLE;
        end else begin
            r_ie    <= w_ie_nxt;
            r_ip    <= w_ip_nxt;
            r_pend  <= w_pend_nxt;
            r_src_q <= i_src;
            r_isr   <= w_isr_nxt;
            r_irq   <= w_irq_nxt;
            r_vec   <= w_vec_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign o_ie   = r_ie;
    assign o_ip   = r_ip;
    assign o_pend = r_pend;
    assign o_irq  = r_irq;
    assign o_vec  = r_vec;
    assign o_isr  = r_isr;

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Bench for int_ctrl_multi: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a rule-level reference model.
module tb_int_ctrl_multi;

    localparam int        N    = 5;
    localparam logic [4:0] EDGE = 5'b00101;
`ifdef INT_CTRL_SW_TRIG_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d_byte;
    logic [2:0] d_op;
    logic [4:0] d_src;
    logic       d_ack, d_reti;
    logic [7:0] ie, ip;
    logic [4:0] pend;
    logic       irq;
    logic [2:0] vec;
    logic [1:0] isr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_ctrl_multi #(.N_SRC(5), .DATA_W(8), .EDGE_MASK(5'b00101), .VEC_W(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte(d_byte), .i_op(d_op), .i_src(d_src),
        .i_ack(d_ack), .i_reti(d_reti), .o_ie(ie), .o_ip(ip), .o_pend(pend),
        .o_irq(irq), .o_vec(vec), .o_isr(isr)
    );

    // Reference model state
    bit [7:0] m_ie, m_ip;
    bit [4:0] m_pend, m_srcq;
    bit       m_hi, m_lo, m_irq;
    int       m_vec;

    task automatic model_reset();
        m_ie = '0; m_ip = '0; m_pend = '0; m_srcq = '0;
        m_hi = 0; m_lo = 0; m_irq = 0; m_vec = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: evaluate the controller rules on the pre-edge state, then commit
    task automatic cycle();
        int a, cand;
        bit [4:0] el, pend_n;
        bit [7:0] ie_n, ip_n;
        bit hi_n, lo_n, irq_n, take, allowed, set, clr;
        int vec_n;
        a = int'(d_byte[3:1]);
        el = '0;
        for (int i = 0; i < N; i++) el[i] = m_pend[i] & m_ie[i] & m_ie[7];
        cand = -1;
        for (int i = 0; i < N; i++) if (cand < 0 && el[i] && m_ip[i]) cand = i;
        for (int i = 0; i < N; i++) if (cand < 0 && el[i]) cand = i;
        allowed = (cand >= 0) && ((!m_hi && !m_lo) || (!m_hi && m_lo && m_ip[cand]));
        irq_n = m_irq; vec_n = m_vec; take = 0;
        if (!m_irq) begin
            if (allowed) begin irq_n = 1; vec_n = cand; end
        end else if (d_ack) begin
            irq_n = 0; take = 1;
        end else if (!el[m_vec]) begin
            irq_n = 0;
        end
        hi_n = m_hi; lo_n = m_lo;
        if (d_reti) begin
            if (m_hi) hi_n = 0; else lo_n = 0;
        end
        if (take) begin
            if (m_ip[m_vec]) hi_n = 1; else lo_n = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                set = (d_src[i] && !m_srcq[i]) || (SW && d_op == 3'd6 && a == i);
                clr = (d_op == 3'd5 && a == i) || (take && m_vec == i);
                pend_n[i] = set ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            end else begin
                pend_n[i] = d_src[i];
            end
        end
        ie_n = m_ie; ip_n = m_ip;
        case (d_op)
            3'd1: ie_n = d_byte;
            3'd2: ie_n[a] = d_byte[0];
            3'd3: ip_n = d_byte;
            3'd4: ip_n[a] = d_byte[0];
            default: ;
        endcase
        @(posedge clk);
        #1;
        m_ie = ie_n; m_ip = ip_n; m_pend = pend_n; m_srcq = d_src;
        m_hi = hi_n; m_lo = lo_n; m_irq = irq_n; m_vec = vec_n;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] b, input logic [4:0] src,
                         input logic ack, input logic reti);
        d_op = op; d_byte = b; d_src = src; d_ack = ack; d_reti = reti;
    endtask

    typedef struct {
        logic [2:0] op;  logic [7:0] b;  logic [4:0] src; logic ack; logic reti;
        logic [7:0] ie;  logic [7:0] ip; logic [4:0] pend; logic irq; logic [2:0] vec; logic [1:0] isr;
    } vec_t;

    vec_t tbl [35];

    initial begin
        //          op    byte   src       ack reti  ie     ip     pend      irq vec   isr
        tbl[0]  = '{3'd1, 8'h81, 5'b00000, 0, 0, 8'h81, 8'h00, 5'b00000, 0, 3'd0, 2'b00};
        tbl[1]  = '{3'd0, 8'h00, 5'b00001, 0, 0, 8'h81, 8'h00, 5'b00001, 0, 3'd0, 2'b00};
        tbl[2]  = '{3'd0, 8'h00, 5'b00001, 0, 0, 8'h81, 8'h00, 5'b00001, 1, 3'd0, 2'b00};
        tbl[3]  = '{3'd0, 8'h00, 5'b00001, 1, 0, 8'h81, 8'h00, 5'b00000, 0, 3'd0, 2'b01};
        tbl[4]  = '{3'd0, 8'h00, 5'b00000, 0, 1, 8'h81, 8'h00, 5'b00000, 0, 3'd0, 2'b00};
        tbl[5]  = '{3'd1, 8'h83, 5'b00000, 0, 0, 8'h83, 8'h00, 5'b00000, 0, 3'd0, 2'b00};
        tbl[6]  = '{3'd3, 8'h02, 5'b00000, 0, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd0, 2'b00};
        tbl[7]  = '{3'd0, 8'h00, 5'b00011, 0, 0, 8'h83, 8'h02, 5'b00011, 0, 3'd0, 2'b00};
        tbl[8]  = '{3'd0, 8'h00, 5'b00011, 0, 0, 8'h83, 8'h02, 5'b00011, 1, 3'd1, 2'b00};
        tbl[9]  = '{3'd0, 8'h00, 5'b00011, 1, 0, 8'h83, 8'h02, 5'b00011, 0, 3'd1, 2'b10};
        tbl[10] = '{3'd0, 8'h00, 5'b00001, 0, 0, 8'h83, 8'h02, 5'b00001, 0, 3'd1, 2'b10};
        tbl[11] = '{3'd0, 8'h00, 5'b00001, 0, 1, 8'h83, 8'h02, 5'b00001, 0, 3'd1, 2'b00};
        tbl[12] = '{3'd0, 8'h00, 5'b00001, 0, 0, 8'h83, 8'h02, 5'b00001, 1, 3'd0, 2'b00};
        tbl[13] = '{3'd0, 8'h00, 5'b00001, 1, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd0, 2'b01};
        tbl[14] = '{3'd0, 8'h00, 5'b00011, 0, 0, 8'h83, 8'h02, 5'b00010, 0, 3'd0, 2'b01};
        tbl[15] = '{3'd0, 8'h00, 5'b00011, 0, 0, 8'h83, 8'h02, 5'b00010, 1, 3'd1, 2'b01};
        tbl[16] = '{3'd0, 8'h00, 5'b00010, 1, 0, 8'h83, 8'h02, 5'b00010, 0, 3'd1, 2'b11};
        tbl[17] = '{3'd0, 8'h00, 5'b00000, 0, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b11};
        tbl[18] = '{3'd0, 8'h00, 5'b00000, 0, 1, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b01};
        tbl[19] = '{3'd0, 8'h00, 5'b00000, 0, 1, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b00};
        tbl[20] = '{3'd0, 8'h00, 5'b00000, 1, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b00};
        tbl[21] = '{3'd2, 8'h0B, 5'b00000, 0, 0, 8'hA3, 8'h02, 5'b00000, 0, 3'd1, 2'b00};
        tbl[22] = '{3'd2, 8'h0A, 5'b00000, 0, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b00};
        tbl[23] = '{3'd4, 8'h05, 5'b00000, 0, 0, 8'h83, 8'h06, 5'b00000, 0, 3'd1, 2'b00};
        tbl[24] = '{3'd4, 8'h04, 5'b00000, 0, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b00};
        tbl[25] = '{3'd0, 8'h00, 5'b00001, 0, 0, 8'h83, 8'h02, 5'b00001, 0, 3'd1, 2'b00};
        tbl[26] = '{3'd0, 8'h00, 5'b00001, 0, 0, 8'h83, 8'h02, 5'b00001, 1, 3'd0, 2'b00};
        tbl[27] = '{3'd0, 8'h00, 5'b00001, 1, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd0, 2'b01};
        tbl[28] = '{3'd0, 8'h00, 5'b00011, 0, 0, 8'h83, 8'h02, 5'b00010, 0, 3'd0, 2'b01};
        tbl[29] = '{3'd0, 8'h00, 5'b00011, 0, 0, 8'h83, 8'h02, 5'b00010, 1, 3'd1, 2'b01};
        tbl[30] = '{3'd0, 8'h00, 5'b00011, 1, 1, 8'h83, 8'h02, 5'b00010, 0, 3'd1, 2'b10};
        tbl[31] = '{3'd0, 8'h00, 5'b00000, 0, 1, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b00};
        tbl[32] = '{3'd0, 8'h00, 5'b00000, 0, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b00};
        tbl[33] = '{3'd0, 8'h00, 5'b00100, 0, 0, 8'h83, 8'h02, 5'b00100, 0, 3'd1, 2'b00};
        tbl[34] = '{3'd5, 8'h04, 5'b00100, 0, 0, 8'h83, 8'h02, 5'b00000, 0, 3'd1, 2'b00};

        rst_n = 1'b0;
        drive(3'd0, 8'h00, 5'b00000, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("reset_state", {5'b0, ie, ip, pend, irq, vec, isr}, 32'h0);

        foreach (tbl[k]) begin
            drive(tbl[k].op, tbl[k].b, tbl[k].src, tbl[k].ack, tbl[k].reti);
            cycle();
            chk($sformatf("table_%0d", k), {5'b0, ie, ip, pend, irq, vec, isr},
                {5'b0, tbl[k].ie, tbl[k].ip, tbl[k].pend, tbl[k].irq, tbl[k].vec, tbl[k].isr});
        end

        // EA cleared while requesting: irq drops one cycle after the write lands
        drive(3'd0, 8'h00, 5'b00001, 0, 0); cycle();
        chk("drop_pend_set", {27'b0, pend}, 32'h01);
        cycle();
        chk("drop_irq_up", {28'b0, irq, vec}, 32'h8);
        drive(3'd2, 8'h0E, 5'b00001, 0, 0); cycle();
        chk("drop_write", {23'b0, irq, ie}, 32'h103);
        drive(3'd0, 8'h00, 5'b00001, 0, 0); cycle();
        chk("drop_irq_low", {27'b0, irq, pend[0]}, 32'h1);

        // Asynchronous reset in the middle of a request
        drive(3'd1, 8'h83, 5'b00001, 0, 0); cycle();
        drive(3'd0, 8'h00, 5'b00001, 0, 0); cycle();
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {5'b0, ie, ip, pend, irq, vec, isr}, 32'h0);
        d_src = 5'b00000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle();
        cycle();
        chk("post_reset_quiet", {5'b0, ie, ip, pend, irq, vec, isr}, 32'h0);

        // Software trigger on an edge source
        drive(3'd1, 8'h81, 5'b00000, 0, 0); cycle();
        drive(3'd6, 8'h01, 5'b00000, 0, 0); cycle();
        chk("sw_trig_pend", {31'b0, pend[0]}, {31'b0, SW});
        drive(3'd0, 8'h00, 5'b00000, 0, 0); cycle();
        chk("sw_trig_irq", {31'b0, irq}, {31'b0, SW});

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 15));
            b = 8'($urandom);
            case (r)
                10: drive(3'd1, ($urandom_range(0, 3) != 0) ? (b | 8'h80) : b, d_src, 0, 0);
                11: drive(3'd2, b, d_src, 0, 0);
                12: drive(3'd3, b, d_src, 0, 0);
                13: drive(3'd4, b, d_src, 0, 0);
                14: drive(3'd5, b, d_src, 0, 0);
                15: drive(3'd6, b, d_src, 0, 0);
                9:  drive(3'd7, b, d_src, 0, 0);
                default: drive(3'd0, b, d_src, 0, 0);
            endcase
            if ($urandom_range(0, 2) == 0) d_src = d_src ^ 5'($urandom);
            d_ack  = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            d_reti = ($urandom_range(0, 9) == 0);
            cycle();
            chk($sformatf("rand_%0d", c), {5'b0, ie, ip, pend, irq, vec, isr},
                {5'b0, m_ie, m_ip, m_pend, m_irq, 3'(m_vec), m_hi, m_lo});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/int_ctrl_multi.md
Name: int_ctrl_multi

Overview:
- Parametrised interrupt controller. Successor to the single 8-bit enable register.
- Holds enable (IE) and priority (IP) registers, each written by full byte or by single bit.
- Latches pending requests (edge or level per source) and arbitrates on two priority levels.
- Presents a vector to the CPU core with an irq/ack handshake and tracks nested in-service levels until return-from-interrupt.

Parameters:
- N_SRC, 5: number of interrupt sources; legal range 1..DATA_W-1.
- DATA_W, 8: width of the IE/IP registers and the write-data bus. Bit DATA_W-1 of IE is EA (global enable).
- EDGE_MASK, 5'b00101: per-source mode; 1 = rising-edge latched, 0 = level.
- VEC_W, 3: width of the vector output; must satisfy 2**VEC_W >= N_SRC.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_byte  in  DATA_W  write data; for bit ops: value = i_byte[0], bit address = i_byte[clog2(DATA_W):1]
- i_op  in  3  operation: 0 NOP, 1 IE_WR_BYTE, 2 IE_WR_BIT, 3 IP_WR_BYTE, 4 IP_WR_BIT, 5 PEND_CLR_BIT, 6 PEND_SET_BIT (optional), 7 NOP
- i_src  in  N_SRC  raw interrupt request lines, synchronous to i_clk
- i_ack  in  1  core accepts the presented vector
- i_reti  in  1  single-cycle return-from-interrupt pulse
- o_ie  out  DATA_W  IE register
- o_ip  out  DATA_W  IP register
- o_pend  out  N_SRC  pending bits
- o_irq  out  1  request to core
- o_vec  out  VEC_W  index of the requested source
- o_isr  out  2  in-service flags; [1] = high level, [0] = low level

Behaviour:
- Reset (async assert, sync-free release): IE, IP, pending, src_q, o_isr, o_irq, o_vec all 0; FSM in IDLE.
- Register writes take effect at the next posedge. Bit op writes only the addressed bit. A bit address >= DATA_W is ignored.
- Bit ops addressing pending bits >= N_SRC are ignored.
- Edge sources:
  - src_q is a registered copy of i_src.
  - Pending sets when i_src & ~src_q.
  - Pending clears on ack of that source or on PEND_CLR_BIT.
  - If set and clear occur in the same cycle, set wins.
- Level sources: pending = i_src, registered. PEND_CLR has no lasting effect.
- Eligibility: elig[i] = pend[i] & IE[i] & IE[DATA_W-1].
- Winner selection:
  - Candidate = eligible source with IP[i] = 1, lowest index first; otherwise lowest-index eligible source.
  - Allowed if o_isr == 0, or if o_isr == 01 and the candidate is high priority.
  - Nothing is allowed while o_isr[1] = 1.
- FSM IDLE:
  - If an allowed candidate exists: o_vec <= candidate, o_irq <= 1, go to REQ.
  - Latency from pend/IE change to o_irq is 1 cycle.
- FSM REQ:
  - o_vec is frozen.
  - On i_ack: o_irq <= 0; set o_isr[IP[o_vec]]; clear pend[o_vec] if it is an edge source; go to IDLE.
  - If the frozen source is no longer eligible and i_ack is low: drop o_irq next cycle and go to IDLE.
  - An ack arriving while o_irq = 0 is ignored.
- i_reti:
  - Clears o_isr[1] if set, else clears o_isr[0].
  - With o_isr == 0 it is a no-op.
  - If i_reti and i_ack arrive in the same cycle, reti is applied first, then ack sets the flag.
- In IDLE, re-arbitration happens every cycle, so a new high-priority source can preempt a low-level service (nesting depth 2).
- Writes to IE/IP during REQ are allowed. A disable is handled by the drop rule above.

Optional Feature:
- Macro: INT_CTRL_SW_TRIG_EN.
- With it defined: op 6 sets pend[addr] <= 1 for an edge source (a software-triggered interrupt). On a level source op 6 has no effect.
- Without it: op 6 behaves as NOP and pending is driven by hardware only.

Test Plan:
1. Reset, then op1 with i_byte=8'h81, then a rising edge on i_src[0] -> o_pend[0]=1 next cycle; o_irq=1 with o_vec=0 one cycle later. i_ack -> o_irq=0, o_isr=01, o_pend[0]=0.
2. IE=8'h83, IP=8'h02, edges on src0 and src1 in the same cycle -> o_vec=1 (high priority wins); after its ack o_isr=10. i_reti -> o_isr=00; then o_vec=0 is served.
3. Nesting: src0 in service (o_isr=01), then a src1 high-priority edge -> o_irq=1, o_vec=1. Ack -> o_isr=11; first reti -> 01; second reti -> 00.
4. During REQ for src0, op2 with i_byte=8'h0E (clear EA) -> o_irq=0 next cycle; o_pend[0] is still 1.
5. Assert i_rst_n=0 mid-REQ with no clock edge -> all outputs 0 immediately. Release -> IDLE with no spurious irq.
6. With INT_CTRL_SW_TRIG_EN defined: op6 with i_byte=8'h01 and EA/IE[0] set -> o_pend[0]=1 and o_irq=1 one cycle later. Without the macro -> no change.
